// File: rtl/ours_axi4_aw_w_order_sched.sv
// N_INPUT:1 AXI4 AW/W write scheduler: round-robin AW grant, order FIFO steers W beats in AW order.
// Optional weighted round-robin (adds cfg_weight port): define OURS_AW_W_SCHED_WRR_EN.
module ours_axi4_aw_w_order_sched #(
  parameter int unsigned N_INPUT        = 4,
  parameter int unsigned AW_WIDTH       = 32,
  parameter int unsigned W_WIDTH        = 64,
  parameter int unsigned WLAST_POSITION = 0,
  parameter int unsigned ORDER_DEPTH    = 4,
  parameter int unsigned WEIGHT_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [N_INPUT-1:0]                   slave_awvld,
  input  logic [N_INPUT-1:0][AW_WIDTH-1:0]     slave_aw,
  output logic [N_INPUT-1:0]                   slave_awrdy,
  input  logic [N_INPUT-1:0]                   slave_wvld,
  input  logic [N_INPUT-1:0][W_WIDTH-1:0]      slave_w,
  output logic [N_INPUT-1:0]                   slave_wrdy,
  output logic                                 master_awvld,
  output logic [AW_WIDTH-1:0]                  master_aw,
  input  logic                                 master_awrdy,
  output logic                                 master_wvld,
  output logic [W_WIDTH-1:0]                   master_w,
  input  logic                                 master_wrdy,
  output logic [$clog2(ORDER_DEPTH+1)-1:0]     order_cnt,
  output logic                                 clk_en
`ifdef OURS_AW_W_SCHED_WRR_EN
  ,
  input  logic [N_INPUT-1:0][WEIGHT_WIDTH-1:0] cfg_weight
`endif
);

  localparam int unsigned IDX_W = $clog2(N_INPUT);
  localparam int unsigned PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(ORDER_DEPTH + 1);

  if (N_INPUT < 2 || ORDER_DEPTH < 1 || WEIGHT_WIDTH < 1 || WLAST_POSITION >= W_WIDTH) begin : g_param_check
    $error("ours_axi4_aw_w_order_sched: illegal parameter combination");
  end

  logic [IDX_W-1:0]                  rr_ptr;
  logic [IDX_W-1:0]                  rr_nxt;
  logic [IDX_W-1:0]                  grant_q;
  logic [IDX_W-1:0]                  grant;
  logic [IDX_W-1:0]                  cand_idx;
  logic                              grant_found;
  logic                              aw_lock;
  logic                              lock_nxt;
  logic [ORDER_DEPTH-1:0][IDX_W-1:0] fifo_mem;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [CNT_W-1:0]                  cnt;
  logic [IDX_W-1:0]                  head;
  logic                              full;
  logic                              empty;
  logic                              aw_hs;
  logic                              w_hs;
  logic                              push;
  logic                              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == ORDER_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
    return (32'(p) == N_INPUT - 1) ? '0 : p + IDX_W'(1);
  endfunction

  assign full  = (32'(cnt) == ORDER_DEPTH);
  assign empty = (cnt == '0);
  assign head  = fifo_mem[rd_ptr];

  // AW grant: a locked (offered but not accepted) grant is held; otherwise first requester from rr_ptr.
  always_comb begin
    grant       = grant_q;
    grant_found = 1'b0;
    cand_idx    = '0;
    if (aw_lock) begin
      grant_found = slave_awvld[grant_q];
    end else begin
      for (int unsigned i = 0; i < N_INPUT; i++) begin
        cand_idx = IDX_W'((32'(rr_ptr) + i) % N_INPUT);
        if (!grant_found && slave_awvld[cand_idx]) begin
          grant_found = 1'b1;
          grant       = cand_idx;
        end
      end
    end
  end

  // AW mux toward the master port; everything is forced quiet while rstn is low.
  always_comb begin
    master_awvld = 1'b0;
    master_aw    = '0;
    slave_awrdy  = '0;
    if (rstn && grant_found && !full) begin
      master_awvld       = 1'b1;
      master_aw          = slave_aw[grant];
      slave_awrdy[grant] = master_awrdy;
    end
  end

  // W steering from the order FIFO head.
  always_comb begin
    master_wvld = 1'b0;
    master_w    = '0;
    slave_wrdy  = '0;
    if (rstn && !empty) begin
      master_wvld      = slave_wvld[head];
      master_w         = slave_w[head];
      slave_wrdy[head] = master_wrdy;
    end
  end

  assign aw_hs = master_awvld & master_awrdy;
  assign w_hs  = master_wvld & master_wrdy;
  assign push  = aw_hs;
  assign pop   = w_hs & master_w[WLAST_POSITION];

  always_comb begin
    lock_nxt = aw_lock;
    if (aw_hs) begin
      lock_nxt = 1'b0;
    end else if (master_awvld) begin
      lock_nxt = 1'b1;
    end
  end

  assign order_cnt = cnt;
  assign clk_en    = ~rstn | (|slave_awvld) | (|slave_wvld) | (cnt != '0) | aw_lock;

  // Order FIFO and AW lock state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_lock  <= 1'b0;
      grant_q  <= '0;
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      aw_lock <= lock_nxt;
      if (master_awvld) begin
        grant_q <= grant;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= grant;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef OURS_AW_W_SCHED_WRR_EN
  localparam int unsigned WCNT_W = WEIGHT_WIDTH + 1;

  logic [WEIGHT_WIDTH-1:0] wrr_cnt;
  logic [WEIGHT_WIDTH-1:0] wrr_cnt_nxt;
  logic [WCNT_W-1:0]       quantum;
  logic [WCNT_W-1:0]       wrr_base;
  logic [WCNT_W-1:0]       wrr_next;

  // Pointer port keeps priority until its quantum of grants is used; a zero weight counts as one.
  always_comb begin
    rr_nxt      = rr_ptr;
    wrr_cnt_nxt = wrr_cnt;
    quantum     = (cfg_weight[grant] == '0) ? WCNT_W'(1) : {1'b0, cfg_weight[grant]};
    wrr_base    = (grant == rr_ptr) ? {1'b0, wrr_cnt} : '0;
    wrr_next    = wrr_base + WCNT_W'(1);
    if (aw_hs) begin
      if (wrr_next >= quantum) begin
        rr_nxt      = idx_inc(grant);
        wrr_cnt_nxt = '0;
      end else begin
        rr_nxt      = grant;
        wrr_cnt_nxt = wrr_next[WEIGHT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr  <= '0;
      wrr_cnt <= '0;
    end else begin
      rr_ptr  <= rr_nxt;
      wrr_cnt <= wrr_cnt_nxt;
    end
  end
`else
  always_comb begin
    rr_nxt = rr_ptr;
    if (aw_hs) begin
      rr_nxt = idx_inc(grant);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ours_axi4_aw_w_order_sched.sv
// Directed self-checking bench for ours_axi4_aw_w_order_sched (4 ports, order depth 4).
module tb_ours_axi4_aw_w_order_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned AWW = 32;
  localparam int unsigned WW  = 64;
  localparam int unsigned DEP = 4;
  localparam int unsigned WTW = 4;
  localparam int unsigned CW  = $clog2(DEP + 1);

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [N-1:0]          slave_awvld;
  logic [N-1:0][AWW-1:0] slave_aw;
  logic [N-1:0]          slave_awrdy;
  logic [N-1:0]          slave_wvld;
  logic [N-1:0][WW-1:0]  slave_w;
  logic [N-1:0]          slave_wrdy;
  logic                  master_awvld;
  logic [AWW-1:0]        master_aw;
  logic                  master_awrdy;
  logic                  master_wvld;
  logic [WW-1:0]         master_w;
  logic                  master_wrdy;
  logic [CW-1:0]         order_cnt;
  logic                  clk_en;
`ifdef OURS_AW_W_SCHED_WRR_EN
  logic [N-1:0][WTW-1:0] cfg_weight;
`endif

  int checks = 0;
  int errors = 0;
  int seq1[5];
  int seq3[4];
  int seq6[7];

  ours_axi4_aw_w_order_sched #(
    .N_INPUT        (N),
    .AW_WIDTH       (AWW),
    .W_WIDTH        (WW),
    .WLAST_POSITION (0),
    .ORDER_DEPTH    (DEP),
    .WEIGHT_WIDTH   (WTW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .slave_awvld  (slave_awvld),
    .slave_aw     (slave_aw),
    .slave_awrdy  (slave_awrdy),
    .slave_wvld   (slave_wvld),
    .slave_w      (slave_w),
    .slave_wrdy   (slave_wrdy),
    .master_awvld (master_awvld),
    .master_aw    (master_aw),
    .master_awrdy (master_awrdy),
    .master_wvld  (master_wvld),
    .master_w     (master_w),
    .master_wrdy  (master_wrdy),
    .order_cnt    (order_cnt),
    .clk_en       (clk_en)
`ifdef OURS_AW_W_SCHED_WRR_EN
    ,
    .cfg_weight   (cfg_weight)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] aw_of(input int p);
    return 64'(32'hA000_0000 | 32'(p));
  endfunction

  function automatic logic [63:0] w_of(input int p, input int beat, input logic last);
    return 64'hD000_0000_0000_0000 | (64'(p) << 8) | (64'(beat) << 4) | {63'b0, last};
  endfunction

  function automatic logic [63:0] one_hot(input int p);
    return 64'(1) << p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; callers settle #1 before checking.
  task automatic cyc(input logic [N-1:0] awv, input logic awr, input logic [N-1:0] wv, input logic wr);
    @(negedge clk);
    slave_awvld  = awv;
    master_awrdy = awr;
    slave_wvld   = wv;
    master_wrdy  = wr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq1 = '{0, 1, 2, 3, 0};
    seq3 = '{2, 3, 0, 1};
`ifdef OURS_AW_W_SCHED_WRR_EN
    seq6 = '{0, 1, 2, 3, 3, 3, 0};
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
`else
    seq6 = '{0, 1, 2, 3, 0, 1, 2};
`endif
    rstn         = 1'b0;
    slave_awvld  = '0;
    slave_wvld   = '0;
    master_awrdy = 1'b0;
    master_wrdy  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      slave_aw[i] = AWW'(aw_of(i));
      slave_w[i]  = w_of(i, 0, 1'b1);
    end

    // Reset: outputs quiet even with requests present, clk_en high.
    #2;
    slave_awvld  = '1;
    slave_wvld   = '1;
    master_awrdy = 1'b1;
    master_wrdy  = 1'b1;
    #1;
    check("rst_awvld", master_awvld, 0);
    check("rst_aw", master_aw, 0);
    check("rst_awrdy", slave_awrdy, 0);
    check("rst_wvld", master_wvld, 0);
    check("rst_wrdy", slave_wrdy, 0);
    check("rst_cnt", order_cnt, 0);
    check("rst_clken", clk_en, 1);
    slave_awvld  = '0;
    slave_wvld   = '0;
    master_awrdy = 1'b0;
    master_wrdy  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("idle_clken", clk_en, 0);

    // All ports request: grants 0,1,2,3,0; W follows the previous cycle's grant.
    for (int k = 0; k < 5; k++) begin
      cyc(4'hF, 1'b1, 4'hF, 1'b1);
      #1;
      check("t1_aw", master_aw, aw_of(seq1[k]));
      check("t1_awrdy", slave_awrdy, one_hot(seq1[k]));
      if (k == 0) begin
        check("t1_wvld_empty", master_wvld, 0);
      end else begin
        check("t1_wrdy", slave_wrdy, one_hot(seq1[k-1]));
        check("t1_w", master_w, w_of(seq1[k-1], 0, 1'b1));
      end
    end
    cyc(4'h0, 1'b1, 4'hF, 1'b1);
    #1;
    check("t1_cnt_tail", order_cnt, 1);
    check("t1_w_tail", master_w, w_of(0, 0, 1'b1));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t1_cnt_empty", order_cnt, 0);

    // Port2 burst of 4 then port0; port0 W waits behind port2's wlast.
    cyc(4'b0100, 1'b1, 4'b0001, 1'b1);
    slave_w[2] = w_of(2, 0, 1'b0);
    #1;
    check("t2a_awrdy", slave_awrdy, 4'b0100);
    check("t2a_aw", master_aw, aw_of(2));
    check("t2a_wrdy", slave_wrdy, 0);
    cyc(4'b0001, 1'b1, 4'b0001, 1'b1);
    #1;
    check("t2b_awrdy", slave_awrdy, 4'b0001);
    check("t2b_wrdy", slave_wrdy, 4'b0100);
    check("t2b_wvld", master_wvld, 0);
    check("t2b_cnt", order_cnt, 1);
    for (int b = 0; b < 4; b++) begin
      cyc(4'b0000, 1'b1, 4'b0101, 1'b1);
      slave_w[2] = w_of(2, b, b == 3);
      #1;
      check("t2c_wrdy", slave_wrdy, 4'b0100);
      check("t2c_w", master_w, w_of(2, b, b == 3));
      if (b == 0) check("t2c_cnt", order_cnt, 2);
    end
    cyc(4'b0000, 1'b1, 4'b0001, 1'b1);
    #1;
    check("t2d_wrdy", slave_wrdy, 4'b0001);
    check("t2d_w", master_w, w_of(0, 0, 1'b1));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    slave_w[2] = w_of(2, 0, 1'b1);
    #1;
    check("t2e_cnt", order_cnt, 0);

    // Fill the order FIFO (rr_ptr now 1): grants 1,2,3,0 then full.
    for (int k = 0; k < 4; k++) begin
      cyc(4'hF, 1'b1, 4'h0, 1'b0);
      #1;
      check("t3_aw", master_aw, aw_of((k + 1) % 4));
    end
    cyc(4'hF, 1'b1, 4'h0, 1'b0);
    #1;
    check("t3_full_cnt", order_cnt, 4);
    check("t3_full_awvld", master_awvld, 0);
    check("t3_full_awrdy", slave_awrdy, 0);
    cyc(4'hF, 1'b1, 4'b0010, 1'b1);
    #1;
    check("t3_pop_awvld", master_awvld, 0);
    check("t3_pop_wrdy", slave_wrdy, 4'b0010);
    cyc(4'hF, 1'b1, 4'h0, 1'b0);
    #1;
    check("t3_after_cnt", order_cnt, 3);
    check("t3_after_awvld", master_awvld, 1);
    check("t3_after_aw", master_aw, aw_of(1));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t3_refull_cnt", order_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      cyc(4'h0, 1'b0, 4'hF, 1'b1);
      #1;
      check("t3_drain_w", master_w, w_of(seq3[k], 0, 1'b1));
    end
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t3_drained_cnt", order_cnt, 0);

    // Port1 held under master_awrdy=0 while port0 (next in RR order) requests.
    cyc(4'b0010, 1'b0, 4'h0, 1'b0);
    #1;
    check("t4_aw0", master_aw, aw_of(1));
    check("t4_awrdy0", slave_awrdy, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0011, 1'b0, 4'h0, 1'b0);
      #1;
      check("t4_aw_hold", master_aw, aw_of(1));
    end
    cyc(4'b0011, 1'b1, 4'h0, 1'b0);
    #1;
    check("t4_aw_hs", master_aw, aw_of(1));
    check("t4_awrdy_hs", slave_awrdy, 4'b0010);
    cyc(4'b0001, 1'b1, 4'h0, 1'b0);
    #1;
    check("t4_aw_next", master_aw, aw_of(0));
    cyc(4'h0, 1'b0, 4'hF, 1'b1);
    #1;
    check("t4_w0", master_w, w_of(1, 0, 1'b1));
    cyc(4'h0, 1'b0, 4'hF, 1'b1);
    #1;
    check("t4_w1", master_w, w_of(0, 0, 1'b1));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t4_cnt", order_cnt, 0);
    check("t4_idle_clken", clk_en, 0);

    // Reset with two bursts outstanding (rr_ptr now 1).
    cyc(4'b0110, 1'b1, 4'h0, 1'b0);
    #1;
    check("t5_aw0", master_aw, aw_of(1));
    cyc(4'b0110, 1'b1, 4'h0, 1'b0);
    #1;
    check("t5_aw1", master_aw, aw_of(2));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t5_cnt2", order_cnt, 2);
    cyc(4'hF, 1'b1, 4'hF, 1'b1);
    rstn = 1'b0;
    #1;
    check("t5_rst_awvld", master_awvld, 0);
    check("t5_rst_aw", master_aw, 0);
    check("t5_rst_wvld", master_wvld, 0);
    check("t5_rst_w", master_w, 0);
    check("t5_rst_awrdy", slave_awrdy, 0);
    check("t5_rst_wrdy", slave_wrdy, 0);
    check("t5_rst_cnt", order_cnt, 0);
    check("t5_rst_clken", clk_en, 1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t5_rel_aw", master_aw, aw_of(0));
    check("t5_rel_awrdy", slave_awrdy, 4'b0001);
    check("t5_rel_wrdy", slave_wrdy, 0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Grant sequence from a fresh reset (weighted when the option is built in).
`ifdef OURS_AW_W_SCHED_WRR_EN
    cfg_weight = {4'd3, 4'd1, 4'd1, 4'd1};
`endif
    for (int k = 0; k < 7; k++) begin
      cyc(4'hF, 1'b1, 4'hF, 1'b1);
      #1;
      check("t6_grant", master_aw, aw_of(seq6[k]));
    end
    cyc(4'h0, 1'b0, 4'hF, 1'b1);
    #1;
    check("t6_tail_w", master_w, w_of(seq6[6], 0, 1'b1));
    cyc(4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check("t6_cnt", order_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
